// File: rtl/node_iter_ctl.sv
// Iterating initiator node: applies the attached child node CNT times to IN.
// Optional child response timeout is enabled by defining NODE_ITER_TIMEOUT_EN.
module node_iter_ctl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] CNT,
  output logic             RD,
  output logic [WIDTH-1:0] RES,
  output logic             ERR,
  output logic             C_ST,
  output logic [WIDTH-1:0] C_IN,
  input  logic             C_RD,
  input  logic [WIDTH-1:0] C_RES,
  output logic [2:0]       DBG_STATE
);

  // Handshake: a request is a rising edge of ST; the node drops RD while busy
  // and raises it again once RES is valid. The child side uses the same rule,
  // with C_ST held high until the child acknowledges by dropping C_RD.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("node_iter_ctl: TIMEOUT must be at least 1");
  end

  state_t           state, state_n;
  logic             st_old;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             rd, rd_n;
  logic [WIDTH-1:0] res, res_n;
  logic             err, err_n;
  logic             c_st, c_st_n;
  logic [WIDTH-1:0] c_in, c_in_n;
  logic             st_edge;
  logic             tmo_hit;

  assign st_edge   = ST & ~st_old;
  assign RD        = rd;
  assign RES       = res;
  assign ERR       = err;
  assign C_ST      = c_st;
  assign C_IN      = c_in;
  assign DBG_STATE = state;

`ifdef NODE_ITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent waiting on the child within one iteration.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= '0;
    end else if ((state == S_WAIT_LO || state == S_WAIT_HI) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    rd_n    = rd;
    res_n   = res;
    err_n   = err;
    c_st_n  = c_st;
    c_in_n  = c_in;
    case (state)
      S_IDLE: begin
        if (st_edge) begin
          acc_n   = IN;
          rem_n   = CNT;
          rd_n    = 1'b0;
          err_n   = 1'b0;
          state_n = (CNT == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        c_in_n  = acc;
        c_st_n  = 1'b1;
        state_n = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!C_RD) begin
          c_st_n  = 1'b0;
          state_n = S_WAIT_HI;
        end else if (tmo_hit) begin
          c_st_n  = 1'b0;
          err_n   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_WAIT_HI: begin
        if (C_RD) begin
          acc_n   = C_RES;
          rem_n   = rem - WIDTH'(1);
          state_n = (rem == WIDTH'(1)) ? S_DONE : S_ISSUE;
        end else if (tmo_hit) begin
          c_st_n  = 1'b0;
          err_n   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        res_n   = acc;
        rd_n    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= S_IDLE;
      st_old <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      rd     <= 1'b1;
      res    <= '0;
      err    <= 1'b0;
      c_st   <= 1'b0;
      c_in   <= '0;
    end else begin
      state  <= state_n;
      st_old <= ST;
      acc    <= acc_n;
      rem    <= rem_n;
      rd     <= rd_n;
      res    <= res_n;
      err    <= err_n;
      c_st   <= c_st_n;
      c_in   <= c_in_n;
    end
  end

endmodule

// File: tb/tb_node_iter_ctl.sv
// Bench for node_iter_ctl: successor child model, directed runs, queued expectations.
module tb_node_iter_ctl;

  localparam int W   = 16;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         st;
  logic [W-1:0] in_v;
  logic [W-1:0] cnt_v;
  logic         rd;
  logic [W-1:0] res;
  logic         err;
  logic         c_st;
  logic [W-1:0] c_in;
  logic         c_rd;
  logic [W-1:0] c_res;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  node_iter_ctl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .ST(st), .IN(in_v), .CNT(cnt_v),
    .RD(rd), .RES(res), .ERR(err),
    .C_ST(c_st), .C_IN(c_in), .C_RD(c_rd), .C_RES(c_res),
    .DBG_STATE(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Child node model: 0 = successor (RES = IN + 1), 1 = stuck with C_RD high
  int           child_mode = 0;
  logic         ch_st_old;
  logic [1:0]   ch_ph;
  logic [W-1:0] ch_op;

  always @(posedge clk) begin
    if (!rst) begin
      c_rd      <= 1'b1;
      c_res     <= '0;
      ch_st_old <= 1'b0;
      ch_ph     <= 2'd0;
      ch_op     <= '0;
    end else begin
      ch_st_old <= c_st;
      if (child_mode == 0) begin
        case (ch_ph)
          2'd0: if (c_st && !ch_st_old) begin
            c_rd  <= 1'b0;
            ch_op <= c_in;
            ch_ph <= 2'd1;
          end
          2'd1: begin
            c_res <= ch_op + W'(1);
            ch_ph <= 2'd2;
          end
          default: begin
            c_rd  <= 1'b1;
            ch_ph <= 2'd0;
          end
        endcase
      end
    end
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_nst_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on each RD rise outside reset, pop and compare one run result
  logic rd_prev   = 1'b1;
  logic c_st_prev = 1'b0;
  int   nst_seen  = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!rd && rd_prev) nst_seen = 0;
      if (c_st && !c_st_prev) nst_seen++;
      if (rd && !rd_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: RD rose at cycle %0d with nothing expected", cyc);
        end else begin
          check("run_res", res, exp_q.pop_front());
          check("run_err", err, exp_err_q.pop_front());
          check("run_child_starts", nst_seen, exp_nst_q.pop_front());
          check("run_done_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
    end else begin
      nst_seen = 0;
    end
    rd_prev   = rd;
    c_st_prev = c_st;
  end

  // Driver: one start edge; optionally queue the expected outcome (latency from the edge)
  task automatic issue(input logic [W-1:0] i, input logic [W-1:0] c,
                       input logic [W-1:0] e_res, input logic e_err, input int e_nst,
                       input int lat, input logic hold, input logic expect_done);
    @(negedge clk);
    in_v  = i;
    cnt_v = c;
    st    = 1'b1;
    if (expect_done) begin
      exp_q.push_back(e_res);
      exp_err_q.push_back(e_err);
      exp_nst_q.push_back(e_nst);
      exp_cyc_q.push_back(cyc + 1 + lat);
    end
    if (!hold) begin
      @(negedge clk);
      st = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d runs still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete(); exp_err_q.delete(); exp_nst_q.delete(); exp_cyc_q.delete();
    end
  endtask

  initial begin
    rst   = 1'b0;
    st    = 1'b0;
    in_v  = '0;
    cnt_v = '0;
    repeat (2) @(negedge clk);
    check("reset_rd", rd, 1);
    check("reset_res", res, 0);
    check("reset_err", err, 0);
    check("reset_c_st", c_st, 0);
    check("reset_c_in", c_in, 0);
    rst = 1'b1;

    // IN=5, CNT=3 with successor child
    issue(16'd5, 16'd3, 16'd8, 1'b0, 3, 16, 1'b0, 1'b1);
    drain(100);

    // CNT=0 passes IN straight through; RES then holds in IDLE
    issue(16'h1234, 16'd0, 16'h1234, 1'b0, 0, 1, 1'b0, 1'b1);
    drain(20);
    repeat (5) @(negedge clk);
    check("res_hold", res, 16'h1234);
    check("rd_idle", rd, 1);

    // Wrap-around through the child
    issue(16'hFFFF, 16'd2, 16'h0001, 1'b0, 2, 11, 1'b0, 1'b1);
    drain(100);

    // CNT=4 run: extra start edge ignored, then reset in the third iteration
    issue(16'd10, 16'd4, '0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    in_v  = 16'h0100;
    cnt_v = 16'd1;
    st    = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_run_c_in", c_in, 16'd12);
    check("mid_run_c_st", c_st, 1);
    check("mid_run_rd", rd, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rd", rd, 1);
    check("abort_res", res, 0);
    check("abort_err", err, 0);
    check("abort_c_st", c_st, 0);
    check("abort_c_in", c_in, 0);
    @(negedge clk);
    rst = 1'b1;

    // IN=1, CNT=1 with ST held high: exactly one run
    issue(16'd1, 16'd1, 16'd2, 1'b0, 1, 6, 1'b1, 1'b1);
    drain(50);
    repeat (10) @(negedge clk);
    check("held_st_rd", rd, 1);
    check("held_st_res", res, 16'd2);
    st = 1'b0;
    @(negedge clk);

    // Child never acknowledges
    child_mode = 1;
`ifdef NODE_ITER_TIMEOUT_EN
    issue(16'h0077, 16'd3, 16'h0077, 1'b1, 1, 10, 1'b0, 1'b1);
    drain(50);
    check("timeout_c_st", c_st, 0);
    repeat (3) @(negedge clk);
    check("timeout_err_hold", err, 1);
`else
    issue(16'h0077, 16'd3, '0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("stall_rd", rd, 0);
    check("stall_err", err, 0);
    check("stall_c_st", c_st, 1);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("final_reset_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/node_iter_ctl.md
# node_iter_ctl

Initiator-side controller for the ST/RD node handshake. It accepts a start request from its parent node like any other node. It then drives ST into one attached child node (typically the successor node) CNT times, feeding each child result back as the next child input. The result is the CNT-fold application of the child function to IN. It sits between a parent node and a single child node in the generated node tree.

## Interface
Parameters:
- WIDTH, 16, data width of IN, CNT, RES, C_IN, C_RES
- TIMEOUT, 255, per-iteration child response limit in cycles; used only with NODE_ITER_TIMEOUT_EN

Ports:
- CLK  input  1  clock; all logic on posedge
- RST  input  1  reset; synchronous, active-low (RST==0 at posedge CLK resets)
- ST  input  1  parent start; a run is requested on a rising edge (ST==1, registered STold==0)
- IN  input  WIDTH  initial value; sampled on the accepted start edge
- CNT  input  WIDTH  iteration count; sampled on the accepted start edge
- RD  output  1  ready to parent; 0 while busy, 1 when idle or done
- RES  output  WIDTH  final result; valid when RD==1 after a run
- ERR  output  1  child timeout flag for the last run
- C_ST  output  1  start to child
- C_IN  output  WIDTH  operand to child; held stable while C_ST high or awaiting C_RD
- C_RD  input  1  child ready
- C_RES  input  WIDTH  child result; sampled when C_RD returns to 1

## Operation
- Reset (RST==0): RD=1, RES=0, ERR=0, C_ST=0, C_IN=0, STold=0, state IDLE. Reset mid-run aborts immediately; the child is abandoned and its late C_RD transitions are ignored.
- STold<=ST every non-reset cycle in every state. Start edges outside IDLE are ignored and not queued.
- IDLE: on a start edge: acc<=IN, rem<=CNT, RD<=0, ERR<=0. If CNT==0, go to DONE; otherwise go to ISSUE.
- ISSUE: C_IN<=acc, C_ST<=1, clear the timeout counter, go to WAIT_LO.
- WAIT_LO: on C_RD==0, C_ST<=0 and go to WAIT_HI. C_ST stays high until the child acknowledges, so the child always sees a clean rising edge.
- WAIT_HI: on C_RD==1: acc<=C_RES, rem<=rem-1. If rem==1, go to DONE; otherwise go to ISSUE.
- DONE: RES<=acc, RD<=1, go to IDLE.
- Arithmetic: acc and RES are WIDTH bits. Wrap-around is whatever the child produces; rem decrements without underflow because rem≥1 in WAIT_HI.
- RES holds its value between runs and through IDLE. It is updated only in DONE.

## Timing
- Accepted edge at posedge k → RD low from k.
- With CNT==0: RD=1 and RES=IN at posedge k+1.
- With the successor node as child, each iteration takes 5 cycles: ISSUE, 2×WAIT_LO, 2×WAIT_HI.
- Total with the successor child: RD=1 and RES valid at posedge k+5·CNT+1.
- Single-cycle RD pulses from the child are honoured, since each level is sampled in its own wait state.
- Parent may drop ST at any time after the edge; holding ST high starts exactly one run.

## Configuration
- NODE_ITER_TIMEOUT_EN defined: a counter runs in WAIT_LO/WAIT_HI and clears in ISSUE. When it reaches TIMEOUT without the awaited C_RD level:
  - C_ST<=0, ERR<=1, go to DONE.
  - RES then receives the acc value at that point, and RD rises next cycle.
  - ERR holds until the next accepted start or reset.
- Not defined: no counter; the controller waits indefinitely and ERR is tied 0.

## Test plan
- Reset: hold RST=0 for 2 cycles → RD=1, RES=0, ERR=0, C_ST=0, C_IN=0.
- Successor child, WIDTH=16, IN=5, CNT=3, start at posedge k → exactly 3 C_ST rising edges; RES=8, RD=1 at k+16.
- IN=0x1234, CNT=0 → no C_ST activity; RES=0x1234, RD=1 at k+1.
- IN=0xFFFF, CNT=2 with successor child → RES=0x0001 (wrap).
- Second ST edge and RST=0 during a run at CNT=4:
  - The extra edge is ignored.
  - RST=0 in the third iteration forces all outputs to reset values.
  - The next start with IN=1, CNT=1 yields RES=2.
- With NODE_ITER_TIMEOUT_EN and TIMEOUT=8, child stub holding C_RD=1 → ERR=1, RD=1, RES=IN ~10 cycles after start, C_ST=0. Without the macro: RD stays 0 and ERR=0.
